d_fifo_drain: RTL and testbench
===============================

# d_fifo_drain

Read-side controller for the two destination FIFOs (D0, D1) at the output of the arquitectura datapath. It watches both FIFO empty flags, issues `pop_d0`/`pop_d1` under round-robin arbitration, captures the popped words into a 2-entry output buffer, and presents them as one valid/ready stream tagged with the source lane. It is the consumer counterpart of the push-side stimulus that feeds the main FIFO, and replaces ad-hoc pop logic in benches and the top level.

## Interface
Parameters:
- `DATA_W`, 6, word width of D0/D1 FIFO data.
- `CNT_W`, 8, width of per-lane word counters (wrap mod 2^CNT_W).

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `reset_L`  in  1  reset, synchronous, active-low.
- `init`  in  1  synchronous soft clear of counters, arbiter pointer and error state; buffer untouched.
- `fifo_empty_d0`  in  1  D0 empty, registered, already reflects a pop taken at the same edge.
- `fifo_empty_d1`  in  1  D1 empty, same rules as D0.
- `data_out_0`  in  DATA_W  D0 read data, valid the cycle after `pop_d0`.
- `data_out_1`  in  DATA_W  D1 read data, valid the cycle after `pop_d1`.
- `sink_ready`  in  1  downstream accepts `word_out` when high with `valid_out`.
- `pop_d0`  out  1  pop request to D0.
- `pop_d1`  out  1  pop request to D1.
- `word_out`  out  DATA_W  buffered head word.
- `lane_out`  out  1  source of `word_out` (0 = D0, 1 = D1).
- `valid_out`  out  1  `word_out`/`lane_out` valid.
- `count_d0`, `count_d1`  out  CNT_W  words popped per lane.
- `idle_out`  out  1  high in IDLE state.
- `error_out`  out  1  sticky sequence error (see Configuration).

## Operation
- FSM states: IDLE, ACTIVE. Reset/`init` → IDLE.
- IDLE → ACTIVE: either empty flag low. ACTIVE → IDLE: both empty, no pop in flight, buffer occupancy 0. `idle_out` = (state == IDLE).
- Pop eligibility: `occ + inflight < 2`, where `occ` ∈ {0,1,2} buffer entries and `inflight` ∈ {0,1} pop issued last cycle. Occupancy counts a same-cycle dequeue (`valid_out && sink_ready`) as freeing a slot.
- At most one pop per cycle. Requests: `!fifo_empty_d0`, `!fifo_empty_d1`. Both requesting → round-robin grant; pointer toggles to other lane after each grant. Single requester → granted regardless of pointer. Pointer resets to D0.
- `pop_dX` is combinational from registered state and empty flags; never asserted when `fifo_empty_dX` is high.
- Capture: cycle after pop, `data_out_X` and lane tag written into buffer tail. Buffer is FIFO-ordered; head drives `word_out`/`lane_out`.
- `count_dX` increments on each `pop_dX`; wraps 2^CNT_W−1 → 0.
- Simultaneous capture and dequeue with `occ`=2 impossible by eligibility rule; with `occ`=1, both occur and `occ` stays 1.
- `init` high: counters, pointer, `error_out` cleared; in-flight capture still completes; pops blocked that cycle.
- `reset_L` low mid-transfer: everything cleared, in-flight word dropped.

## Timing
- Reset values: `pop_d0`=0, `pop_d1`=0, `word_out`=0, `lane_out`=0, `valid_out`=0, counts=0, `idle_out`=1, `error_out`=0.
- Pop → `valid_out` latency: 2 cycles with empty buffer (pop at N, capture at N+1 edge, visible N+2... `valid_out` high in cycle N+2).
- Sustained throughput 1 word/cycle with `sink_ready` held high.
- `sink_ready` low: at most 2 words buffered; pops stop once `occ + inflight` = 2.

## Configuration
- `DRAIN_CHECK_EN` defined: per-lane sequence checker. First captured word per lane after reset/`init` seeds expected value; each subsequent word must equal previous+1 mod 2^DATA_W, else `error_out` set (sticky until reset/`init`).
- Not defined: checker absent, `error_out` tied 0.

## Structure
- Package `drain_pkg`: state enum (IDLE, ACTIVE), lane constants `LANE_D0`=0, `LANE_D1`=1, buffer depth constant 2.
- Sub-module `rr_arb2`: two-requester round-robin arbiter with registered pointer, one-hot grant.

## Test plan
- Reset: hold `reset_L`=0 3 cycles with both FIFOs non-empty → no pops, all outputs at reset values, `idle_out`=1.
- D0 only holds 0x2C..0x31, `sink_ready`=1 → six consecutive `pop_d0`, `word_out` 0x2C..0x31 with `lane_out`=0, `count_d0`=6, back to IDLE.
- Both lanes non-empty, 4 words each → grants alternate D0,D1,D0,...; output lanes alternate; counts 4/4.
- `sink_ready`=0 with 5 words in D1 → exactly 2 pops, `valid_out` high holding first word; release → remaining 3 popped, order preserved.
- `DRAIN_CHECK_EN`: D0 sends 0x0C,0x0D,0x0F → `error_out` rises cycle after 0x0F capture, stays high; `init` pulse clears it.
- Counter wrap: 256 D0 words → `count_d0` returns to 0.

Source files
------------

// File: rtl/d_fifo_drain_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// drain_pkg : state, lane and buffer constants shared by d_fifo_drain blocks
// Rev 1.0
// ----------------------------------------------------------------------------
package drain_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam logic LANE_D0   = 1'b0;
  localparam logic LANE_D1   = 1'b1;
  localparam int   BUF_DEPTH = 2;

  function automatic logic other_lane(input logic lane);
    return ~lane;
  endfunction

endpackage
`default_nettype wire

// File: rtl/d_fifo_drain_rr_arb2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arb2 : two-requester round-robin arbiter, registered pointer, one-hot grant
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_arb2
  import drain_pkg::*;
(
  input  logic       clk,
  input  logic       reset_L,
  input  logic       i_init,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_grant
);

  logic ptr_q, ptr_d;

  always_comb begin
    o_grant = 2'b00;
    ptr_d   = ptr_q;
    if (i_en) begin
      if (i_req == 2'b11) begin
        o_grant = (ptr_q == LANE_D1) ? 2'b10 : 2'b01;
      end else begin
        o_grant = i_req;
      end
    end
    // Priority moves to the lane that was not just served.
    if (o_grant[LANE_D0]) begin
      ptr_d = other_lane(LANE_D0);
    end else if (o_grant[LANE_D1]) begin
      ptr_d = other_lane(LANE_D1);
    end
    if (i_init) begin
      ptr_d = LANE_D0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      ptr_q <= LANE_D0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/d_fifo_drain.sv
`default_nettype none
// ----------------------------------------------------------------------------
// d_fifo_drain : round-robin read controller for D0/D1 FIFOs into a tagged
//                valid/ready stream. Optional macro DRAIN_CHECK_EN adds a
//                per-lane +1 sequence checker driving error_out.
// Rev 1.0
// ----------------------------------------------------------------------------
module d_fifo_drain
  import drain_pkg::*;
#(
  parameter int DATA_W = 6,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              init,
  input  logic              fifo_empty_d0,
  input  logic              fifo_empty_d1,
  input  logic [DATA_W-1:0] data_out_0,
  input  logic [DATA_W-1:0] data_out_1,
  input  logic              sink_ready,
  output logic              pop_d0,
  output logic              pop_d1,
  output logic [DATA_W-1:0] word_out,
  output logic              lane_out,
  output logic              valid_out,
  output logic [CNT_W-1:0]  count_d0,
  output logic [CNT_W-1:0]  count_d1,
  output logic              idle_out,
  output logic              error_out
);

  state_e                 state_q, state_d;
  logic [1:0]             occ_q, occ_d;
  logic                   inflight_q, inflight_d;
  logic                   inflight_lane_q, inflight_lane_d;
  logic [1:0][DATA_W-1:0] buf_data_q, buf_data_d;
  logic [1:0]             buf_lane_q, buf_lane_d;
  logic [CNT_W-1:0]       count_d0_q, count_d0_d;
  logic [CNT_W-1:0]       count_d1_q, count_d1_d;

  logic                   deq;
  logic [1:0]             occ_after_deq;
  logic [2:0]             slots_used;
  logic                   pop_en;
  logic [1:0]             req;
  logic [1:0]             grant;
  logic [DATA_W-1:0]      cap_word;

  assign valid_out     = (occ_q != 2'd0);
  assign deq           = valid_out && sink_ready;
  assign occ_after_deq = occ_q - {1'b0, deq};
  // A slot freed by this cycle's dequeue is already available to a new pop.
  assign slots_used    = {1'b0, occ_after_deq} + {2'b00, inflight_q};
  assign pop_en        = reset_L && !init && (slots_used < 3'(BUF_DEPTH));
  assign req           = {!fifo_empty_d1, !fifo_empty_d0};
  assign cap_word      = (inflight_lane_q == LANE_D1) ? data_out_1 : data_out_0;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_L (reset_L),
    .i_init  (init),
    .i_req   (req),
    .i_en    (pop_en),
    .o_grant (grant)
  );

  assign pop_d0   = grant[LANE_D0];
  assign pop_d1   = grant[LANE_D1];
  assign word_out = buf_data_q[0];
  assign lane_out = buf_lane_q[0];
  assign count_d0 = count_d0_q;
  assign count_d1 = count_d1_q;
  assign idle_out = (state_q == IDLE);

  always_comb begin
    buf_data_d = buf_data_q;
    buf_lane_d = buf_lane_q;
    occ_d      = occ_q;
    if (deq) begin
      buf_data_d[0] = buf_data_q[1];
      buf_lane_d[0] = buf_lane_q[1];
      occ_d         = occ_after_deq;
    end
    if (inflight_q) begin
      if (occ_d == 2'd0) begin
        buf_data_d[0] = cap_word;
        buf_lane_d[0] = inflight_lane_q;
      end else begin
        buf_data_d[1] = cap_word;
        buf_lane_d[1] = inflight_lane_q;
      end
      occ_d = occ_d + 2'd1;
    end

    inflight_d      = pop_d0 || pop_d1;
    inflight_lane_d = pop_d1 ? LANE_D1 : LANE_D0;

    count_d0_d = init ? '0 : count_d0_q + CNT_W'(pop_d0);
    count_d1_d = init ? '0 : count_d1_q + CNT_W'(pop_d1);

    state_d = state_q;
    if (init) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty_d0 || !fifo_empty_d1) state_d = ACTIVE;
        end
        ACTIVE: begin
          if (fifo_empty_d0 && fifo_empty_d1 && !inflight_q && occ_q == 2'd0)
            state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q         <= IDLE;
      occ_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_lane_q <= LANE_D0;
      buf_data_q      <= '0;
      buf_lane_q      <= '0;
      count_d0_q      <= '0;
      count_d1_q      <= '0;
    end else begin
      state_q         <= state_d;
      occ_q           <= occ_d;
      inflight_q      <= inflight_d;
      inflight_lane_q <= inflight_lane_d;
      buf_data_q      <= buf_data_d;
      buf_lane_q      <= buf_lane_d;
      count_d0_q      <= count_d0_d;
      count_d1_q      <= count_d1_d;
    end
  end

`ifdef DRAIN_CHECK_EN
  logic [1:0]             seen_q, seen_d;
  logic [1:0][DATA_W-1:0] last_q, last_d;
  logic                   err_q, err_d;

  // First word per lane only seeds; later words must step by exactly one.
  always_comb begin
    seen_d = seen_q;
    last_d = last_q;
    err_d  = err_q;
    if (init) begin
      seen_d = '0;
      err_d  = 1'b0;
    end else if (inflight_q) begin
      if (seen_q[inflight_lane_q] &&
          (cap_word != last_q[inflight_lane_q] + DATA_W'(1)))
        err_d = 1'b1;
      seen_d[inflight_lane_q] = 1'b1;
      last_d[inflight_lane_q] = cap_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      seen_q <= '0;
      last_q <= '0;
      err_q  <= 1'b0;
    end else begin
      seen_q <= seen_d;
      last_q <= last_d;
      err_q  <= err_d;
    end
  end

  assign error_out = err_q;
`else
  assign error_out = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_d_fifo_drain.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_d_fifo_drain : self-checking bench for d_fifo_drain
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_d_fifo_drain;

  localparam int DATA_W = 6;
  localparam int CNT_W  = 8;
`ifdef DRAIN_CHECK_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_L = 1'b0;
  logic              init = 1'b0;
  logic              sink_ready = 1'b0;
  logic              fifo_empty_d0 = 1'b1;
  logic              fifo_empty_d1 = 1'b1;
  logic [DATA_W-1:0] data_out_0 = '0;
  logic [DATA_W-1:0] data_out_1 = '0;
  logic              pop_d0, pop_d1, lane_out, valid_out, idle_out, error_out;
  logic [DATA_W-1:0] word_out;
  logic [CNT_W-1:0]  count_d0, count_d1;

  int n_cmp = 0;
  int n_fail = 0;
  int pops0 = 0;
  int pops1 = 0;
  int delivered = 0;
  bit log_en = 1'b0;
  logic [DATA_W-1:0] q0[$], q1[$], e0[$], e1[$];
  logic lane_log[$];
  logic grant_log[$];

  typedef struct {
    int         n0;
    int         n1;
    logic [5:0] b0;
    logic [5:0] b1;
    bit         toggle;
    logic [7:0] exp_c0;
    logic [7:0] exp_c1;
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  d_fifo_drain #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_L(reset_L), .init(init),
    .fifo_empty_d0(fifo_empty_d0), .fifo_empty_d1(fifo_empty_d1),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .sink_ready(sink_ready),
    .pop_d0(pop_d0), .pop_d1(pop_d1), .word_out(word_out), .lane_out(lane_out),
    .valid_out(valid_out), .count_d0(count_d0), .count_d1(count_d1),
    .idle_out(idle_out), .error_out(error_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // External FIFO pair: registered empty flags and read data one cycle after pop.
  always @(posedge clk) begin
    if (pop_d0 && q0.size() > 0) data_out_0 <= q0.pop_front();
    if (pop_d1 && q1.size() > 0) data_out_1 <= q1.pop_front();
    fifo_empty_d0 <= (q0.size() == 0);
    fifo_empty_d1 <= (q1.size() == 0);
  end

  // Scoreboard: every delivered word must be the oldest outstanding word of its lane.
  always @(negedge clk) begin
    if (reset_L) begin
      check("pop_d0_vs_empty", 32'(pop_d0 & fifo_empty_d0), 32'd0);
      check("pop_d1_vs_empty", 32'(pop_d1 & fifo_empty_d1), 32'd0);
      check("one_pop_per_cycle", 32'(pop_d0 & pop_d1), 32'd0);
      check("outstanding_le_2", 32'((pops0 + pops1 - delivered) <= 2), 32'd1);
      if (valid_out && sink_ready) begin
        if (lane_out == 1'b0) begin
          if (e0.size() == 0) check("spurious_d0_word", 32'd1, 32'd0);
          else check("word_d0", 32'(word_out), 32'(e0.pop_front()));
        end else begin
          if (e1.size() == 0) check("spurious_d1_word", 32'd1, 32'd0);
          else check("word_d1", 32'(word_out), 32'(e1.pop_front()));
        end
        if (log_en) lane_log.push_back(lane_out);
        delivered++;
      end
      if (pop_d0) begin pops0++; if (log_en) grant_log.push_back(1'b0); end
      if (pop_d1) begin pops1++; if (log_en) grant_log.push_back(1'b1); end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int lane, input logic [DATA_W-1:0] w);
    if (lane == 0) begin q0.push_back(w); e0.push_back(w); end
    else begin q1.push_back(w); e1.push_back(w); end
  endtask

  task automatic pulse_init();
    tick();
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  task automatic wait_drain(input bit toggle, input string name);
    int k;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (e0.size() == 0 && e1.size() == 0 && q0.size() == 0 && q1.size() == 0 && idle_out)
        break;
      tick();
      sink_ready = toggle ? ~sink_ready : 1'b1;
    end
    check({name, "_drain_done"}, 32'(k < 2000), 32'd1);
    sink_ready = 1'b1;
  endtask

  initial begin
    int p, tot0, tot1;
    bit found;
    logic prev_err;

    vecs[0] = '{n0: 3, n1: 0, b0: 6'h05, b1: 6'h00, toggle: 1'b0, exp_c0: 8'd3, exp_c1: 8'd0};
    vecs[1] = '{n0: 0, n1: 4, b0: 6'h00, b1: 6'h3E, toggle: 1'b0, exp_c0: 8'd0, exp_c1: 8'd4};
    vecs[2] = '{n0: 3, n1: 5, b0: 6'h10, b1: 6'h20, toggle: 1'b1, exp_c0: 8'd3, exp_c1: 8'd5};
    vecs[3] = '{n0: 1, n1: 1, b0: 6'h3F, b1: 6'h00, toggle: 1'b1, exp_c0: 8'd1, exp_c1: 8'd1};

    // Reset held with both FIFOs non-empty
    for (int i = 0; i < 2; i++) begin
      load(0, 6'(6'h10 + i));
      load(1, 6'(6'h20 + i));
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_pop_d0", 32'(pop_d0), 32'd0);
      check("rst_pop_d1", 32'(pop_d1), 32'd0);
      check("rst_word", 32'(word_out), 32'd0);
      check("rst_lane", 32'(lane_out), 32'd0);
      check("rst_valid", 32'(valid_out), 32'd0);
      check("rst_count_d0", 32'(count_d0), 32'd0);
      check("rst_count_d1", 32'(count_d1), 32'd0);
      check("rst_idle", 32'(idle_out), 32'd1);
      check("rst_error", 32'(error_out), 32'd0);
    end
    tick();
    reset_L = 1'b1;
    sink_ready = 1'b1;
    wait_drain(1'b0, "rst_preload");
    check("rst_preload_cnt0", 32'(count_d0), 32'd2);
    check("rst_preload_cnt1", 32'(count_d1), 32'd2);

    // D0 only, 0x2C..0x31: back-to-back pops and two-cycle pop-to-valid latency
    pulse_init();
    tick();
    for (int i = 0; i < 6; i++) load(0, 6'(6'h2C + i));
    found = 1'b0;
    for (int t = 0; t < 6 && !found; t++) begin
      @(negedge clk);
      if (pop_d0) found = 1'b1;
    end
    check("d0_first_pop_seen", 32'(found), 32'd1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      check("d0_pop_d0", 32'(pop_d0), 32'(k < 6));
      check("d0_pop_d1", 32'(pop_d1), 32'd0);
      check("d0_valid", 32'(valid_out), 32'(k >= 2));
      if (k == 2) check("d0_first_word", 32'(word_out), 32'h2C);
    end
    wait_drain(1'b0, "d0");
    check("d0_count", 32'(count_d0), 32'd6);
    check("d0_idle", 32'(idle_out), 32'd1);

    // Both lanes, 4 words each: grants and output lanes alternate from D0
    pulse_init();
    lane_log.delete();
    grant_log.delete();
    log_en = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      load(0, 6'(6'h01 + i));
      load(1, 6'(6'h31 + i));
    end
    wait_drain(1'b0, "rr");
    log_en = 1'b0;
    check("rr_grants", 32'(grant_log.size()), 32'd8);
    check("rr_outputs", 32'(lane_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < grant_log.size() && i < lane_log.size(); i++) begin
      check("rr_grant_lane", 32'(grant_log[i]), 32'(i % 2));
      check("rr_out_lane", 32'(lane_log[i]), 32'(i % 2));
    end
    check("rr_count_d0", 32'(count_d0), 32'd4);
    check("rr_count_d1", 32'(count_d1), 32'd4);

    // Back-pressure: 5 words in D1 with sink stalled
    pulse_init();
    sink_ready = 1'b0;
    tick();
    p = pops1;
    for (int i = 0; i < 5; i++) load(1, 6'(6'h08 + i));
    repeat (8) @(negedge clk);
    check("bp_pops_stalled", 32'(pops1 - p), 32'd2);
    check("bp_valid", 32'(valid_out), 32'd1);
    check("bp_word", 32'(word_out), 32'h08);
    check("bp_lane", 32'(lane_out), 32'd1);
    repeat (3) @(negedge clk);
    check("bp_word_held", 32'(word_out), 32'h08);
    check("bp_pops_still", 32'(pops1 - p), 32'd2);
    tick();
    sink_ready = 1'b1;
    wait_drain(1'b0, "bp");
    check("bp_pops_total", 32'(pops1 - p), 32'd5);
    check("bp_count_d1", 32'(count_d1), 32'd5);

    // Sequence gap on D0: 0x0C,0x0D,0x0F
    pulse_init();
    tick();
    load(0, 6'h0C);
    load(0, 6'h0D);
    load(0, 6'h0F);
    found = 1'b0;
    prev_err = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (valid_out && word_out == 6'h0F) found = 1'b1;
      else prev_err = error_out;
    end
    check("seq_0f_seen", 32'(found), 32'd1);
    check("seq_err_before_gap", 32'(prev_err), 32'd0);
    check("seq_err_at_gap", 32'(error_out), 32'(CHK_EN));
    wait_drain(1'b0, "seq");
    check("seq_err_sticky", 32'(error_out), 32'(CHK_EN));
    pulse_init();
    @(negedge clk);
    check("seq_err_cleared", 32'(error_out), 32'd0);

    // Table-driven drain scenarios
    foreach (vecs[v]) begin
      pulse_init();
      sink_ready = 1'b1;
      tick();
      for (int i = 0; i < vecs[v].n0; i++) load(0, 6'(vecs[v].b0 + 6'(i)));
      for (int i = 0; i < vecs[v].n1; i++) load(1, 6'(vecs[v].b1 + 6'(i)));
      wait_drain(vecs[v].toggle, "vec");
      check("vec_count_d0", 32'(count_d0), 32'(vecs[v].exp_c0));
      check("vec_count_d1", 32'(count_d1), 32'(vecs[v].exp_c1));
      check("vec_idle", 32'(idle_out), 32'd1);
      check("vec_valid", 32'(valid_out), 32'd0);
    end

    // Counter wrap: 256 D0 words
    pulse_init();
    tick();
    p = pops0;
    for (int i = 0; i < 256; i++) load(0, 6'(i));
    wait_drain(1'b0, "wrap");
    check("wrap_pops", 32'(pops0 - p), 32'd256);
    check("wrap_count_d0", 32'(count_d0), 32'd0);

    // Randomised traffic and back-pressure
    pulse_init();
    tot0 = 0;
    tot1 = 0;
    for (int c = 0; c < 600; c++) begin
      tick();
      if ($urandom_range(0, 2) == 0) begin load(0, 6'($urandom)); tot0++; end
      if ($urandom_range(0, 2) == 0) begin load(1, 6'($urandom)); tot1++; end
      sink_ready = ($urandom_range(0, 3) != 0);
    end
    wait_drain(1'b0, "rand");
    check("rand_count_d0", 32'(count_d0), 32'(tot0 % 256));
    check("rand_count_d1", 32'(count_d1), 32'(tot1 % 256));
    check("rand_idle", 32'(idle_out), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
